// File: rtl/aes_byte_stream_adapter_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_byte_stream_adapter_if
// Brief    : Byte-stream and AES core handshake bundle for the stream adapter.
// Revision : 1.0
// ============================================================================
interface aes_byte_stream_adapter_if;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [7:0]   m_data;
    logic         m_valid;
    logic         m_last;
    logic         m_ready;
    logic         core_start;
    logic         core_encrypt;
    logic [127:0] core_data_in;
    logic [127:0] core_key_in;
    logic [127:0] core_data_out;
    logic         core_busy;
    logic         core_done;

    modport master (
        input  s_data, s_valid, s_last, m_ready, core_data_out, core_busy, core_done,
        output s_ready, m_data, m_valid, m_last, core_start, core_encrypt,
               core_data_in, core_key_in
    );

    modport slave (
        output s_data, s_valid, s_last, m_ready, core_data_out, core_busy, core_done,
        input  s_ready, m_data, m_valid, m_last, core_start, core_encrypt,
               core_data_in, core_key_in
    );
endinterface
`default_nettype wire

// File: rtl/aes_byte_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : aes_byte_stream_adapter
// Brief    : Packs an 8-bit stream into 128-bit AES blocks and re-serialises results.
// Revision : 1.0
// ============================================================================
module aes_byte_stream_adapter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  encrypt_mode,
    input  wire logic [127:0]          key,
    aes_byte_stream_adapter_if.master  bus,
    output logic                       err_timeout,
    output logic [CNT_W-1:0]           blk_count
);
    localparam int          c_wcnt_w = $clog2(TIMEOUT + 1);
    localparam logic [1:0]  c_fill   = 2'd0;
    localparam logic [1:0]  c_launch = 2'd1;
    localparam logic [1:0]  c_wait   = 2'd2;
    localparam logic [1:0]  c_drain  = 2'd3;

    logic [1:0]          r_state;
    logic [3:0]          r_idx;
    logic [c_wcnt_w-1:0] r_wcnt;
    logic                r_last;
    logic [127:0]        r_data;
    logic [127:0]        r_key;
    logic                r_enc;
    logic [127:0]        r_out;
    logic                r_start;
    logic                r_m_valid;
    logic                r_err;
    logic [CNT_W-1:0]    r_blk_count;

    logic                w_run;
    logic [6:0]          w_lo;
    logic                w_wcnt_max;
    logic                w_unused;

    assign w_run      = !rst;
    // Byte k of the block lives at bit 8*(15-k); ~idx equals 15-idx for a 4-bit index.
    assign w_lo       = {~r_idx, 3'b000};
    // The LAUNCH cycle counts as the first waited cycle, so the flag rises TIMEOUT cycles after start.
    assign w_wcnt_max = (r_wcnt == c_wcnt_w'(TIMEOUT - 1));
    assign w_unused   = bus.core_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_fill;
            r_idx       <= '0;
            r_wcnt      <= '0;
            r_last      <= 1'b0;
            r_data      <= '0;
            r_key       <= '0;
            r_enc       <= 1'b0;
            r_out       <= '0;
            r_start     <= 1'b0;
            r_m_valid   <= 1'b0;
            r_err       <= 1'b0;
            r_blk_count <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                c_fill: begin
                    if (bus.s_valid) begin
                        r_data[w_lo +: 8] <= bus.s_data;
                        if (r_idx == 4'd15 || bus.s_last) begin
                            r_state <= c_launch;
                            r_last  <= bus.s_last;
                            r_key   <= key;
                            r_enc   <= encrypt_mode;
                            r_start <= 1'b1;
                            r_idx   <= '0;
                            r_wcnt  <= '0;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                c_launch: begin
                    r_state <= c_wait;
                    r_wcnt  <= c_wcnt_w'(1);
                end
                c_wait: begin
                    if (bus.core_done) begin
                        r_out       <= bus.core_data_out;
                        r_blk_count <= r_blk_count + 1'b1;
                        r_m_valid   <= 1'b1;
                        r_state     <= c_drain;
                    end else if (w_wcnt_max) begin
                        r_err   <= 1'b1;
                        r_data  <= '0;
                        r_last  <= 1'b0;
                        r_state <= c_fill;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                c_drain: begin
                    if (bus.m_ready) begin
                        r_out <= {r_out[119:0], 8'h00};
                        if (r_idx == 4'd15) begin
                            r_idx     <= '0;
                            r_m_valid <= 1'b0;
                            r_last    <= 1'b0;
                            r_data    <= '0;
                            r_state   <= c_fill;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                default: r_state <= c_fill;
            endcase
        end
    end

    // Every output is forced low while reset is held, not just after the reset edge.
    assign bus.s_ready      = w_run && (r_state == c_fill);
    assign bus.m_valid      = w_run && r_m_valid;
    assign bus.m_data       = r_out[127:120] & {8{w_run}};
    assign bus.m_last       = w_run && r_m_valid && (r_idx == 4'd15) && r_last;
    assign bus.core_start   = w_run && r_start;
    assign bus.core_encrypt = w_run && r_enc;
    assign bus.core_data_in = r_data & {128{w_run}};
    assign bus.core_key_in  = r_key & {128{w_run}};
    assign err_timeout      = w_run && r_err;
    assign blk_count        = r_blk_count & {CNT_W{w_run}};
endmodule
`default_nettype wire
